// File: rtl/jb_srx_pkg.sv
// Shared types and constants for the SRX request sequencer.
package jb_srx_pkg;

    localparam logic [3:0] REQ_DPD   = 4'h0;
    localparam logic [3:0] REQ_HIRES = 4'h1;
    localparam logic [3:0] REQ_VSWR  = 4'h2;
    localparam logic [3:0] REQ_AVAIL = 4'hF;

    // srx_ctrl tdata layout: {type[7:4], reserved[3], ant[2:0]}
    localparam int unsigned TD_ANT_LSB  = 0;
    localparam int unsigned TD_ANT_W    = 3;
    localparam int unsigned TD_TYPE_LSB = 4;
    localparam int unsigned TD_TYPE_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_WAIT_ACK,
        S_CAPTURE,
        S_NEXT
    } state_t;

endpackage

// File: rtl/jb_rr_mask_next.sv
// Round-robin search: first set bit of mask strictly after cur, wrapping.
module jb_rr_mask_next #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] mask,
    input  logic [2:0]   cur,
    output logic [2:0]   next
);

    logic       found;
    logic [2:0] idx;

    // Scanning N positions ends on cur itself, so a lone set bit reselects it.
    always_comb begin
        next  = cur;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = 3'((32'(cur) + i) % N);
            if (!found && mask[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jb_srx_req_seq.sv
// SRX control-protocol initiator: rotates antenna-switch requests and
// forwards a fixed-length capture per acknowledged antenna.
module jb_srx_req_seq
    import jb_srx_pkg::*;
#(
    parameter int unsigned N_ANTENNAS = 8,
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  enable,
    input  logic [N_ANTENNAS-1:0] ant_mask,
    input  logic [3:0]            req_type,
    input  logic [CNT_W-1:0]      capture_len,
    input  logic [CNT_W-1:0]      settle_cycles,
    input  logic [CNT_W-1:0]      timeout_cycles,
    input  logic                  err_clr,
    output logic [7:0]            m_srx_ctrl_tdata,
    output logic                  m_srx_ctrl_tvalid,
    input  logic                  m_srx_ctrl_tready,
    input  logic [SAMPLE_W-1:0]   s_srx_tdata,
    input  logic                  s_srx_tvalid,
    output logic                  s_srx_tready,
    input  logic [7:0]            s_srx_tuser,
    output logic [SAMPLE_W-1:0]   cap_tdata,
    output logic                  cap_tvalid,
    output logic                  cap_tlast,
    output logic [2:0]            cap_ant,
    output logic                  busy,
    output logic                  ant_done,
    output logic                  timeout_err,
    output logic [7:0]            timeout_cnt
);

    state_t            state, state_nx;
    logic [2:0]        cur_ant, sel_ant;
    logic [3:0]        type_q;
    logic [CNT_W-1:0]  wait_cnt, smp_cnt, len_q, settle_q, tmo_q;
    logic              ack, tmo_hit, beat, last_beat, cap_end;
    logic              unused_tuser;

    assign unused_tuser = ^s_srx_tuser[7:3];

    jb_rr_mask_next #(.N(N_ANTENNAS)) u_next (
        .mask (ant_mask),
        .cur  (cur_ant),
        .next (sel_ant)
    );

    assign ack       = (state == S_WAIT_ACK) && (wait_cnt >= settle_q)
                       && (s_srx_tuser[2:0] == cur_ant);
    assign tmo_hit   = (state == S_WAIT_ACK) && !ack && (tmo_q != '0)
                       && (wait_cnt == tmo_q - CNT_W'(1));
    assign beat      = (state == S_CAPTURE) && s_srx_tvalid && (len_q != '0);
    assign last_beat = beat && (smp_cnt == len_q - CNT_W'(1));
    assign cap_end   = (state == S_CAPTURE) && ((len_q == '0) || last_beat);

    always_comb begin
        state_nx          = state;
        m_srx_ctrl_tvalid = 1'b0;
        m_srx_ctrl_tdata  = '0;
        busy              = (state != S_IDLE);
        // Held low during reset so the idle drain does not show through.
        s_srx_tready      = !axis_areset && ((state == S_IDLE) || (state == S_CAPTURE));
        unique case (state)
            S_IDLE:     if (enable && (ant_mask != '0)) state_nx = S_SELECT;
            S_SELECT:   state_nx = S_REQ;
            S_REQ: begin
                m_srx_ctrl_tvalid = 1'b1;
                m_srx_ctrl_tdata[TD_TYPE_LSB +: TD_TYPE_W] = type_q;
                m_srx_ctrl_tdata[TD_ANT_LSB +: TD_ANT_W]   = cur_ant;
                if (m_srx_ctrl_tready) state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack)          state_nx = S_CAPTURE;
                else if (tmo_hit) state_nx = S_NEXT;
            end
            S_CAPTURE:  if (cap_end) state_nx = S_NEXT;
            S_NEXT:     state_nx = (enable && (ant_mask != '0)) ? S_SELECT : S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state       <= S_IDLE;
            cur_ant     <= 3'(N_ANTENNAS - 1);
            type_q      <= '0;
            wait_cnt    <= '0;
            smp_cnt     <= '0;
            len_q       <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            cap_tdata   <= '0;
            cap_tvalid  <= 1'b0;
            cap_tlast   <= 1'b0;
            cap_ant     <= '0;
            ant_done    <= 1'b0;
            timeout_err <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state      <= state_nx;
            cap_tvalid <= beat;
            cap_tlast  <= last_beat;
            ant_done   <= tmo_hit || cap_end;
            if (beat) cap_tdata <= s_srx_tdata;

            if (state == S_SELECT) begin
                cur_ant  <= sel_ant;
                cap_ant  <= sel_ant;
                type_q   <= req_type;
                len_q    <= capture_len;
                settle_q <= settle_cycles;
                tmo_q    <= timeout_cycles;
            end

            if (state == S_REQ)
                wait_cnt <= '0;
            else if ((state == S_WAIT_ACK) && (wait_cnt != '1))
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (ack)       smp_cnt <= '0;
            else if (beat) smp_cnt <= smp_cnt + CNT_W'(1);

            if (tmo_hit)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            if (tmo_hit && (timeout_cnt != 8'hFF))
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

endmodule

// File: doc/jb_srx_req_seq.md
Name: jb_srx_req_seq

Overview:
- Initiator side of the SRX control protocol: the sequencer that issues antenna-switch requests on the srx_ctrl stream and consumes the returned SRX sample stream.
- Steps round-robin through enabled antennas. Per antenna: request a switch, wait for the antenna-tagged tuser acknowledgement, then forward a fixed-length capture to a downstream capture/statistics block.
- Sits between the SRX control block (responder) and observation-path DSP. Replaces the DPD core as requester in VSWR/debug builds.

Parameters:
- N_ANTENNAS, 8, number of antennas; antenna index width is 3 bits (N_ANTENNAS <= 8).
- SAMPLE_W, 32, SRX sample width ({Q[31:16], I[15:0]}).
- CNT_W, 16, width of capture_len, settle_cycles and timeout_cycles.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_areset  in  1  asynchronous, active-high reset.
- enable  in  1  run sequencer; sampled only in S_IDLE and at capture end.
- ant_mask  in  N_ANTENNAS  antennas included in the rotation.
- req_type  in  4  request type placed in tdata[7:4]: 0 = DPD, 2 = VSWR.
- capture_len  in  CNT_W  samples per antenna; 0 = no capture.
- settle_cycles  in  CNT_W  minimum wait after request before tuser is trusted.
- timeout_cycles  in  CNT_W  acknowledge timeout; 0 = disabled.
- err_clr  in  1  clears timeout_err (single-cycle pulse).
- m_srx_ctrl_tdata  out  8  {req_type, 1'b0, ant[2:0]}.
- m_srx_ctrl_tvalid  out  1  request valid.
- m_srx_ctrl_tready  in  1  request accepted.
- s_srx_tdata  in  SAMPLE_W  SRX samples.
- s_srx_tvalid  in  1  sample valid.
- s_srx_tready  out  1  sequencer accepting samples.
- s_srx_tuser  in  8  [2:0] = antenna currently routed.
- cap_tdata  out  SAMPLE_W  forwarded sample.
- cap_tvalid  out  1  forwarded sample valid; no backpressure.
- cap_tlast  out  1  last sample of the capture.
- cap_ant  out  3  antenna of the current capture.
- busy  out  1  state != S_IDLE.
- ant_done  out  1  1-cycle pulse at the end of each antenna slot.
- timeout_err  out  1  sticky; set on acknowledge timeout.
- timeout_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset values: all outputs 0; state S_IDLE; internal cur_ant = N_ANTENNAS-1, so the first selection after reset scans from antenna 0.
- S_IDLE:
  - Go to S_SELECT if enable=1 and ant_mask != 0.
  - ant_mask == 0 holds S_IDLE with busy=0.
- S_SELECT (1 cycle):
  - cur_ant <= next set bit of ant_mask strictly after cur_ant, wrapping modulo N_ANTENNAS.
  - A single set bit reselects the same antenna.
  - Go to S_REQ.
- S_REQ:
  - m_srx_ctrl_tvalid=1 with tdata stable until tvalid&tready; then go to S_WAIT_ACK.
  - tvalid never drops before the handshake, even if enable falls.
- S_WAIT_ACK:
  - Wait counter starts at 0 on entry.
  - Ack = (wait counter >= settle_cycles) && s_srx_tuser[2:0] == cur_ant. The settle rule covers same-antenna re-requests, where tuser already matches.
  - On ack: go to S_CAPTURE, sample counter = 0.
  - If timeout_cycles != 0 and the counter reaches timeout_cycles-1 without ack: set timeout_err, increment timeout_cnt (saturate at 255), pulse ant_done, go to S_NEXT.
  - If ack and timeout occur in the same cycle, ack wins.
- s_srx_tready:
  - 0 in S_REQ and S_WAIT_ACK, so data of unknown antenna is stalled.
  - 1 in S_CAPTURE and S_IDLE; S_IDLE drains and discards.
- S_CAPTURE:
  - Each s_srx_tvalid&s_srx_tready beat is registered to cap_* with 1-cycle latency.
  - cap_ant = cur_ant. cap_tlast on beat capture_len-1.
  - After the last beat, pulse ant_done and go to S_NEXT.
  - capture_len == 0: no cap beats; ant_done pulses on the cycle after entry.
- S_NEXT (1 cycle): go to S_SELECT if enable=1 and ant_mask != 0, else S_IDLE.
- Configuration timing:
  - ant_mask is sampled in S_SELECT only.
  - capture_len, settle_cycles and timeout_cycles are latched on S_SELECT exit; mid-slot changes take effect in the next slot.
- err_clr vs timeout:
  - err_clr clears timeout_err; it does not clear timeout_cnt.
  - A timeout in the same cycle as err_clr leaves timeout_err = 1.
- Reset mid-operation:
  - Asynchronous return to reset values; any in-flight request is dropped.
  - The downstream control responder tolerates a dropped request because it is always ready.
- Counters are CNT_W wide and never wrap inside a state, since the comparisons terminate them.

Decomposition:
- Package jb_srx_pkg holds:
  - the request-type constants (DPD=4'h0, HIRES=4'h1, VSWR=4'h2, AVAIL=4'hF);
  - the state enum (S_IDLE, S_SELECT, S_REQ, S_WAIT_ACK, S_CAPTURE, S_NEXT);
  - the srx_ctrl tdata field positions.
- One sub-module: jb_rr_mask_next, a combinational next-set-bit search with wrap, taking (mask, cur) and returning next.

Test Plan:
- Basic rotation: mask=8'h25, capture_len=4, settle=3, responder grants after 5 cycles -> requests go to ants 0, 2, 5, 0; each slot gives 4 cap beats with tlast on beat 4, cap_ant correct, one ant_done per slot.
- Same antenna: mask=8'h08, settle=6, tuser already 3 -> no ack before wait count 6; tready stays 0 until ack; capture repeats on ant 3.
- Timeout: responder never updates tuser, timeout=20 -> timeout_err set after 20 cycles, timeout_cnt=1, next antenna requested. With err_clr coincident with a second timeout -> err remains 1, cnt=2.
- Backpressure on ctrl: m_srx_ctrl_tready low for 7 cycles, enable dropped meanwhile -> tvalid and tdata stable for 7 cycles; after handshake the slot completes and the sequencer returns to S_IDLE.
- Gappy data and zero length: s_srx_tvalid 50% duty, capture_len=10 -> exactly 10 beats in order. capture_len=0 -> no beats, ant_done still pulses.
- Async reset in S_CAPTURE mid-beat -> all outputs 0 immediately. After release with enable=1, the first request is to the lowest set bit of the mask.
